uart_rx_con: RTL and testbench
==============================

UART_RX_CON -- requirements
Module: uart_rx_con

Interface
REQ-001 The block SHALL have parameters, one per line:
- OVERSAMPLE, default 16: baud_tick pulses per bit period; even, at least 4.
- DATA_BITS, default 8: data bits per frame, from 5 to 9.

REQ-002 The block SHALL have ports, one per line (name, direction, width, meaning):
- clk, input, 1: single clock; all logic rises on its positive edge.
- reset, input, 1: asynchronous, active-low reset.
- rx, input, 1: serial line, asynchronous to clk, idles high.
- baud_tick, input, 1: one-clk pulse at OVERSAMPLE times the baud rate.
- rx_ack, input, 1: consumer acknowledges rx_data.
- rx_data, output, DATA_BITS: last good frame payload.
- rx_valid, output, 1: rx_data holds an unacknowledged frame.
- frame_err, output, 1: one-clk pulse when the stop bit samples 0.
- overrun_err, output, 1: sticky; a frame completed while rx_valid was unacknowledged.
- busy, output, 1: state is not IDLE.

Function
REQ-003 rx SHALL pass through a 2-flop synchronizer; the synchronized output is rx_s, and both flops reset to 1.
REQ-004 tick_cnt and bit_cnt SHALL advance only on clk edges where baud_tick=1; state and counters SHALL hold when baud_tick=0.
REQ-005 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-006 IDLE: on a baud_tick with rx_s=0, go to START with tick_cnt=0; otherwise stay.
REQ-007 START: on each baud_tick, tick_cnt increments.
- At the tick where tick_cnt=OVERSAMPLE/2-1 (mid start bit): if rx_s=0, go to DATA with tick_cnt=0 and bit_cnt=0.
- At that tick, if rx_s=1, return to IDLE (glitch rejected, no error).
REQ-008 DATA: tick_cnt counts 0..OVERSAMPLE-1; at the tick where tick_cnt=OVERSAMPLE-1, the block SHALL:
- shift rx_s into the shift-register MSB, shifting right (LSB first on the line);
- clear tick_cnt and increment bit_cnt.
- After the DATA_BITS-th sample, go to STOP.
REQ-009 STOP: at the tick where tick_cnt=OVERSAMPLE-1, sample rx_s.
- If 1: load rx_data from the shift register, set rx_valid, go to IDLE.
- If 0: pulse frame_err for one clk, leave rx_data and rx_valid unchanged, go to WAIT_HIGH.
REQ-010 WAIT_HIGH: on a baud_tick with rx_s=1, go to IDLE. A line held low (break) SHALL NOT start new frames.
REQ-011 rx_valid SHALL clear on the clk edge where rx_ack=1 and rx_valid=1. rx_ack while rx_valid=0 SHALL be ignored.
REQ-012 Frame completion while rx_valid=1 and rx_ack=0 SHALL overwrite rx_data, keep rx_valid=1, and set overrun_err.
REQ-013 Frame completion in the same cycle as rx_ack SHALL load the new data with rx_valid=1 and no overrun; completion wins over the clear.
REQ-014 overrun_err SHALL clear only on an rx_ack clk edge with no simultaneous overrun; set wins over clear.
REQ-015 Latency SHALL be:
- rx_valid and frame_err register on the same clk edge as the stop-sample baud_tick;
- rx to rx_s is 2 clk.
REQ-016 busy SHALL be a registered decode of state != IDLE.
REQ-017 Counter widths SHALL be:
- tick_cnt: $clog2(OVERSAMPLE) bits;
- bit_cnt: $clog2(DATA_BITS+1) bits.
- No counter SHALL wrap without a defined state transition.

Reset
REQ-018 While reset=0, the block SHALL be forced, asynchronously, to:
- state IDLE;
- tick_cnt, bit_cnt, shift register, rx_data all 0;
- rx_valid, frame_err, overrun_err, busy all 0;
- synchronizer flops 1.
REQ-019 Reset asserted mid-frame SHALL abort the frame with no rx_valid or frame_err.
REQ-020 After reset releases, reception SHALL begin only at the next falling edge of rx_s in IDLE.

Verification
REQ-021 Good frame, OVERSAMPLE=16, DATA_BITS=8: send 0xA5 (line order start 0, 1,0,1,0,0,1,0,1, stop 1) -> rx_data=0xA5, rx_valid=1 on the stop-sample tick edge, frame_err=0, busy back to 0.
REQ-022 Glitch: rx low for 4 ticks, then high -> return to IDLE at tick 8, rx_valid=0, frame_err=0.
REQ-023 Framing error: send 0x3C with stop=0, then hold rx low for 40 ticks -> frame_err pulses once, rx_valid=0, no new frame starts, IDLE once rx returns high.
REQ-024 Overrun: send 0x11 without ack, then send 0x22 -> rx_data=0x22, rx_valid=1, overrun_err=1. rx_ack then clears both.
REQ-025 Simultaneous: assert rx_ack on the exact edge 0x55 completes while 0x11 is pending -> rx_data=0x55, rx_valid=1, overrun_err=0.
REQ-026 Reset mid-DATA (after 4 bits of 0xFF) -> all outputs 0 immediately; a following 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_con.sv
// ---------------------------------------------------------------------------
// uart_rx_con
// Oversampling UART receiver. Each frame is one start bit (0), DATA_BITS data
// bits sent LSB first, and one stop bit (1). The start bit is confirmed at its
// midpoint. Every later bit is then sampled one full bit period apart, so each
// sample lands near the middle of its bit.
//
// Parameters
//   OVERSAMPLE : baud_tick pulses per bit period (even, >= 4)
//   DATA_BITS  : data bits per frame (5..9)
//
// Ports
//   clk         : single clock, rising edge
//   reset       : asynchronous active-low reset
//   rx          : serial line, asynchronous to clk, idles high
//   baud_tick   : one-clk pulse at OVERSAMPLE x baud rate
//   rx_ack      : consumer acknowledges rx_data
//   rx_data     : payload of the last good frame
//   rx_valid    : rx_data holds an unacknowledged frame
//   frame_err   : one-clk pulse when the stop bit samples 0
//   overrun_err : sticky; a frame completed while rx_valid was unacknowledged
//   busy        : receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_con #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 baud_tick,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_e;

    logic                 rx_meta_q;
    logic                 rx_s_q;
    state_e               state_q,    state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [DATA_BITS-1:0] rx_data_q,  rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q,  overrun_d;
    logic                 busy_q,     busy_d;
    logic                 frame_done_s;
    logic                 frame_bad_s;

    // Two-flop synchronizer for the asynchronous serial line (idles high)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State register together with the bit-timing counters and shift register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= TICK_ZERO;
            bit_cnt_q  <= BIT_ZERO;
            shift_q    <= {DATA_BITS{1'b0}};
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

    // Next-state logic: everything advances only on baud_tick
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        frame_done_s = 1'b0;
        frame_bad_s  = 1'b0;
        if (baud_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s_q) begin
                        state_d    = ST_START;
                        tick_cnt_d = TICK_ZERO;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end
                ST_START: begin
                    // Re-check the line at the middle of the start bit; a
                    // short low pulse is treated as noise and dropped.
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = TICK_ZERO;
                        if (!rx_s_q) begin
                            state_d   = ST_DATA;
                            bit_cnt_d = BIT_ZERO;
                        end else begin
                            state_d   = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        // LSB arrives first, so shift right with the new bit
                        // entering at the MSB.
                        shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = TICK_ZERO;
                        bit_cnt_d  = bit_cnt_q + BIT_ONE;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end
                ST_STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = TICK_ZERO;
                        if (rx_s_q) begin
                            frame_done_s = 1'b1;
                            state_d      = ST_IDLE;
                        end else begin
                            frame_bad_s  = 1'b1;
                            state_d      = ST_WAIT_HIGH;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end
                ST_WAIT_HIGH: begin
                    // Stay here until the line is released, so that a held
                    // break is not taken as a string of new start bits.
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_HIGH;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    tick_cnt_d = TICK_ZERO;
                    bit_cnt_d  = BIT_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output next-values: a completing frame takes priority over an ack
    always_comb begin
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_bad_s;
        busy_d      = (state_d != ST_IDLE);
        if (frame_done_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_ack) begin
                overrun_d = 1'b1;
            end else if (rx_ack) begin
                overrun_d = 1'b0;
            end else begin
                overrun_d = overrun_q;
            end
        end else if (rx_ack) begin
            // Overrun can only be set while rx_valid is 1, so this branch
            // has no visible effect when rx_valid is already 0.
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data_q   <= {DATA_BITS{1'b0}};
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_con.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_con
// Self-checking bench for uart_rx_con (OVERSAMPLE=16, DATA_BITS=8).
// baud_tick pulses every third clk. Serial frames are driven just after a tick
// edge. The reference model keeps track of the pending data, the valid flag
// and the overrun flag at the frame/ack level.
// ---------------------------------------------------------------------------
module tb_uart_rx_con;

    localparam int OS = 16;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx = 1'b1;
    logic          baud_tick = 1'b0;
    logic          rx_ack = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun_err;
    logic          busy;

    int checks = 0;
    int failures = 0;
    int ferr_cnt = 0;
    int tick_div = 0;

    // Frame-level reference model
    logic [DB-1:0] m_data = '0;
    logic          m_valid = 1'b0;
    logic          m_ovr = 1'b0;

    uart_rx_con #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk(clk), .reset(reset), .rx(rx), .baud_tick(baud_tick), .rx_ack(rx_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .overrun_err(overrun_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // One-clk baud tick every third clk
    initial begin
        forever begin
            @(negedge clk);
            tick_div = (tick_div == 2) ? 0 : tick_div + 1;
            baud_tick = (tick_div == 0);
        end
    end

    // Count frame_err pulses (pre-edge value seen at each posedge)
    always @(posedge clk) begin
        if (frame_err === 1'b1) ferr_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Wait for the next baud_tick edge, then return at the following negedge
    task automatic tick();
        int n;
        n = 0;
        @(posedge clk);
        while (baud_tick !== 1'b1 && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (baud_tick !== 1'b1) begin
            checks++; failures++;
            $display("FAIL tick_timeout: got no baud_tick within %0d clk, required one", n);
        end
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Drive start + data + the first half of the stop bit. The next tick()
    // after this is the stop-bit sampling tick.
    task automatic drive_to_stop(input logic [DB-1:0] d, input logic stop_b);
        tick();
        rx = 1'b0;
        ticks(OS);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            ticks(OS);
        end
        rx = stop_b;
        ticks(OS / 2);
    endtask

    task automatic model_good(input logic [DB-1:0] d, input logic ack);
        if (m_valid && !ack) m_ovr = 1'b1;
        else if (ack) m_ovr = 1'b0;
        m_data = d;
        m_valid = 1'b1;
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h required 00", rx_data); end
        checks++; if ({rx_valid, frame_err, overrun_err, busy} !== 4'b0000) begin failures++; $display("FAIL reset_flags: got %b required 0000", {rx_valid, frame_err, overrun_err, busy}); end
        reset = 1'b1;
        ticks(4);
        checks++; if ({rx_valid, busy} !== 2'b00) begin failures++; $display("FAIL reset_idle: got %b required 00", {rx_valid, busy}); end
    endtask

    task automatic test_good_frame();
        drive_to_stop(8'hA5, 1'b1);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL good_busy_mid: got %b required 1", busy); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL good_valid_early: got %b required 0", rx_valid); end
        tick();
        model_good(8'hA5, 1'b0);
        checks++; if (rx_data !== m_data) begin failures++; $display("FAIL good_data: got %h required %h", rx_data, m_data); end
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL good_valid: got %b required 1", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL good_ferr: got %b required 0", frame_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL good_busy_end: got %b required 0", busy); end
    endtask

    task automatic test_glitch();
        int f0;
        f0 = ferr_cnt;
        tick();
        rx = 1'b0;
        ticks(4);
        rx = 1'b1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_start: got %b required 1", busy); end
        ticks(4);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_before_mid: got %b required 1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_idle_at_mid: got %b required 0", busy); end
        ticks(OS * 2);
        checks++; if (rx_valid !== m_valid || rx_data !== m_data) begin failures++; $display("FAIL glitch_outputs: got %b/%h required %b/%h", rx_valid, rx_data, m_valid, m_data); end
        checks++; if (ferr_cnt != f0) begin failures++; $display("FAIL glitch_ferr: got %0d pulses required 0", ferr_cnt - f0); end
    endtask

    task automatic test_frame_err();
        int f0;
        do_ack();
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL ack_clear: got %b required 0", rx_valid); end
        f0 = ferr_cnt;
        drive_to_stop(8'h3C, 1'b0);
        tick();
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_pulse: got %b required 1", frame_err); end
        checks++; if (rx_valid !== 1'b0 || rx_data !== m_data) begin failures++; $display("FAIL ferr_no_load: got %b/%h required 0/%h", rx_valid, rx_data, m_data); end
        @(negedge clk);
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_one_clk: got %b required 0", frame_err); end
        ticks(OS / 2 - 1 + 40);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ferr_break_hold: got busy %b required 1", busy); end
        checks++; if (ferr_cnt != f0 + 1) begin failures++; $display("FAIL ferr_once: got %0d pulses required 1", ferr_cnt - f0); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL ferr_break_valid: got %b required 0", rx_valid); end
        rx = 1'b1;
        ticks(3);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_release_idle: got %b required 0", busy); end
    endtask

    task automatic test_overrun();
        drive_to_stop(8'h11, 1'b1);
        tick();
        model_good(8'h11, 1'b0);
        checks++; if (rx_data !== m_data || rx_valid !== 1'b1 || overrun_err !== m_ovr) begin failures++; $display("FAIL ovr_first: got %h/%b/%b required %h/1/%b", rx_data, rx_valid, overrun_err, m_data, m_ovr); end
        ticks(4);
        drive_to_stop(8'h22, 1'b1);
        tick();
        model_good(8'h22, 1'b0);
        checks++; if (rx_data !== 8'h22) begin failures++; $display("FAIL ovr_data: got %h required 22", rx_data); end
        checks++; if (rx_valid !== 1'b1 || overrun_err !== 1'b1) begin failures++; $display("FAIL ovr_flags: got %b/%b required 1/1", rx_valid, overrun_err); end
        do_ack();
        checks++; if (rx_valid !== 1'b0 || overrun_err !== 1'b0) begin failures++; $display("FAIL ovr_ack_clear: got %b/%b required 0/0", rx_valid, overrun_err); end
    endtask

    task automatic test_simultaneous();
        drive_to_stop(8'h11, 1'b1);
        tick();
        model_good(8'h11, 1'b0);
        ticks(4);
        drive_to_stop(8'h55, 1'b1);
        // Ticks are three clks apart: raise ack just before the stop-sample edge
        @(negedge clk);
        @(negedge clk);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin failures++; $display("FAIL sim_pending: got %b/%h required 1/11", rx_valid, rx_data); end
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        model_good(8'h55, 1'b1);
        checks++; if (rx_data !== 8'h55) begin failures++; $display("FAIL sim_data: got %h required 55", rx_data); end
        checks++; if (rx_valid !== 1'b1 || overrun_err !== 1'b0) begin failures++; $display("FAIL sim_flags: got %b/%b required 1/0", rx_valid, overrun_err); end
    endtask

    task automatic test_reset_mid();
        int f0;
        f0 = ferr_cnt;
        tick();
        rx = 1'b0;
        ticks(OS);
        rx = 1'b1;
        ticks(OS * 4 + OS / 2);
        reset = 1'b0;
        #1;
        m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
        checks++; if (rx_data !== 8'h00 || {rx_valid, frame_err, overrun_err, busy} !== 4'b0000) begin failures++; $display("FAIL rstmid_outputs: got %h/%b required 00/0000", rx_data, {rx_valid, frame_err, overrun_err, busy}); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        ticks(OS * 2);
        checks++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_idle: got %b/%b required 0/0", busy, rx_valid); end
        drive_to_stop(8'h81, 1'b1);
        tick();
        model_good(8'h81, 1'b0);
        checks++; if (rx_data !== m_data || rx_valid !== 1'b1 || overrun_err !== 1'b0) begin failures++; $display("FAIL rstmid_next: got %h/%b/%b required %h/1/0", rx_data, rx_valid, overrun_err, m_data); end
        checks++; if (ferr_cnt != f0) begin failures++; $display("FAIL rstmid_ferr: got %0d pulses required 0", ferr_cnt - f0); end
    endtask

    task automatic test_random();
        logic [DB-1:0] d;
        logic          good;
        for (int i = 0; i < 12; i++) begin
            d = DB'($urandom);
            good = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                do_ack();
                checks++; if (rx_valid !== 1'b0 || overrun_err !== 1'b0) begin failures++; $display("FAIL rnd_ack %0d: got %b/%b required 0/0", i, rx_valid, overrun_err); end
            end
            drive_to_stop(d, good);
            tick();
            if (good) model_good(d, 1'b0);
            checks++; if (rx_data !== m_data || rx_valid !== m_valid || overrun_err !== m_ovr) begin failures++; $display("FAIL rnd_frame %0d: got %h/%b/%b required %h/%b/%b", i, rx_data, rx_valid, overrun_err, m_data, m_valid, m_ovr); end
            checks++; if (frame_err !== !good) begin failures++; $display("FAIL rnd_ferr %0d: got %b required %b", i, frame_err, !good); end
            rx = 1'b1;
            ticks(3);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
